instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, the PC value loaded at reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 16'hFFFF, the instruction word that stops sequencing.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level, sampled only in IDLE; starts execution.
REQ-006 SHALL have port mem_req  output  1  instruction fetch request.
REQ-007 SHALL have port mem_addr  output  16  fetch address, equal to PC at all times.
REQ-008 SHALL have port mem_ready  input  1  fetch data valid on instr this cycle.
REQ-009 SHALL have port instr  input  16  instruction word from memory.
REQ-010 SHALL have port ir  output  16  instruction register, driven to the decode handlers.
REQ-011 SHALL have port dec_control  input  26  control word decoded from ir.
REQ-012 SHALL have port dec_literal  input  16  literal decoded from ir, sign-extended for branches.
REQ-013 SHALL have port flag_z, flag_n  input  1 each  datapath zero and negative flags.
REQ-014 SHALL have port ctrl  output  26  control word applied to the datapath.
REQ-015 SHALL have port literal  output  16  literal applied to the datapath.
REQ-016 SHALL have port exec_valid  output  1  high only in the EXECUTE cycle.
REQ-017 SHALL have port halted  output  1  high while in HALT.

Function
REQ-018 SHALL implement the states IDLE, FETCH, DECODE, EXECUTE and HALT, with state registers updated on clk.
REQ-019 In IDLE, SHALL move to FETCH on start=1 and SHALL otherwise stay in IDLE.
REQ-020 In FETCH, SHALL set mem_req=1; when mem_ready=1, SHALL load ir<=instr, set PC<=PC+1 (mod 2^16) and move to DECODE; otherwise SHALL hold all state.
REQ-021 SHALL set mem_req=0 in every state except FETCH, so mem_req falls in the cycle after the accepting edge.
REQ-022 In DECODE, when ir==HALT_OPCODE, SHALL move to HALT without latching the decoder outputs.
REQ-023 In DECODE, when ir!=HALT_OPCODE, SHALL register dec_control and dec_literal into ctrl_r and lit_r and move to EXECUTE.
REQ-024 In EXECUTE, SHALL drive ctrl=ctrl_r, literal=lit_r and exec_valid=1 for exactly one cycle, then move to FETCH.
REQ-025 Outside EXECUTE, SHALL drive ctrl=0, literal=0 and exec_valid=0, so no datapath write occurs.
REQ-026 SHALL decode a branch as ir[15:14]==2'b10 and ir[13:12]==2'b11, where ir[11]=0 is brz and ir[11]=1 is brn.
REQ-027 In the EXECUTE cycle of a branch, SHALL sample flag_z for brz or flag_n for brn; if the sampled flag is 1, SHALL set PC<=PC+lit_r (16-bit, wrapping), otherwise SHALL leave PC at the already-incremented value.
REQ-028 SHALL give an instruction a latency of (fetch wait cycles)+3 cycles; with zero-wait memory, SHALL start the next fetch 3 cycles after the previous one.
REQ-029 SHALL keep HALT sticky: halted=1 and mem_req=0 until reset, with start ignored.
REQ-030 SHALL wrap PC from 16'hFFFF to 16'h0000 without any error indication.
REQ-031 SHALL give a change on instr or mem_ready outside FETCH no effect.

Reset
REQ-032 On reset=1, SHALL immediately (asynchronously) enter IDLE with PC=RESET_PC, ir=0, ctrl_r=0, lit_r=0, mem_req=0, ctrl=0, literal=0, exec_valid=0 and halted=0.
REQ-033 SHALL abandon an instruction caught by reset mid-operation (FETCH, DECODE or EXECUTE), with no partial PC update, and SHALL restart only on start after reset deasserts.

Verification
REQ-034 Bench SHALL cover: reset, then start=1 with mem_ready tied to 1 and instr=16'h1234 -> mem_addr 0000, 0001, 0002 on successive fetches, 3 cycles apart, with exec_valid one cycle each.
REQ-035 Bench SHALL cover: mem_ready held low for 4 cycles in FETCH -> mem_req stays 1, PC and ir unchanged, and the instruction completes 7 cycles after FETCH entry.
REQ-036 Bench SHALL cover: brz at PC=0010, dec_literal=FFFC, flag_z=1 -> next mem_addr=000D; the same branch with flag_z=0 -> next mem_addr=0011.
REQ-037 Bench SHALL cover: brn at PC=FFFF, dec_literal=0003, flag_n=1 -> next mem_addr=0003 (wrap).
REQ-038 Bench SHALL cover: instr=FFFF -> halted=1 from the cycle after DECODE, exec_valid never asserted, mem_req=0, and start pulses ignored.
REQ-039 Bench SHALL cover: reset asserted mid-EXECUTE, between edges -> ctrl=0, exec_valid=0 and mem_addr=RESET_PC immediately.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE, looping
//   until the halt opcode is decoded. Decoding itself is external; this block
//   owns the PC and the IR, registers the decoder outputs, and presents them
//   to the datapath for exactly one EXECUTE cycle. Conditional branches
//   (brz / brn) are resolved here against the datapath flags.
//
// Ports
//   clk, reset         clock, async active-high reset
//   start              level, only sampled in IDLE
//   mem_req/mem_addr   fetch request, address (always the PC)
//   mem_ready/instr    fetch handshake and instruction word
//   ir                 instruction register, feeds the external decoder
//   dec_control/_literal  decoder outputs, latched in DECODE
//   flag_z, flag_n     datapath flags, sampled by branches in EXECUTE
//   ctrl, literal      datapath control, non-zero only in EXECUTE
//   exec_valid         EXECUTE cycle marker
//   halted             sticky halt indication
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] instr,
  output logic [15:0] ir,
  input  logic [25:0] dec_control,
  input  logic [15:0] dec_literal,
  input  logic        flag_z,
  input  logic        flag_n,
  output logic [25:0] ctrl,
  output logic [15:0] literal,
  output logic        exec_valid,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [25:0] r_ctrl;
  logic [15:0] r_lit;

  logic        w_is_branch;
  logic        w_flag;
  logic        w_take;
  logic        w_is_halt;

  // Branch class is 4'b1011 in the top nibble; bit 11 picks the flag.
  assign w_is_branch = (r_ir[15:12] == 4'b1011);
  assign w_flag      = r_ir[11] ? flag_n : flag_z;
  assign w_take      = w_is_branch & w_flag;
  assign w_is_halt   = (r_ir == HALT_OPCODE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)     w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = w_is_halt ? S_HALT : S_EXEC;
      S_EXEC:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // PC / IR / latched decode. The PC is bumped at fetch acceptance, so a
  // taken branch offsets from the address of the following instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_ir   <= 16'h0000;
      r_ctrl <= 26'h0;
      r_lit  <= 16'h0000;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir <= instr;
            r_pc <= r_pc + 16'h0001;
          end
        end
        S_DECODE: begin
          // The halt word never reaches the datapath registers.
          if (!w_is_halt) begin
            r_ctrl <= dec_control;
            r_lit  <= dec_literal;
          end
        end
        S_EXEC: begin
          if (w_take) r_pc <= r_pc + r_lit;
        end
        default: ;
      endcase
    end
  end

  // Outputs: datapath sees a zero control word outside EXECUTE so nothing
  // can be written while the sequencer is fetching or decoding.
  assign mem_req    = (r_state == S_FETCH);
  assign mem_addr   = r_pc;
  assign ir         = r_ir;
  assign exec_valid = (r_state == S_EXEC);
  assign ctrl       = exec_valid ? r_ctrl : 26'h0;
  assign literal    = exec_valid ? r_lit  : 16'h0000;
  assign halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready = 1'b1;
  logic [15:0] instr;
  logic [15:0] ir;
  logic [25:0] dec_control;
  logic [15:0] dec_literal;
  logic        flag_z = 1'b1;
  logic        flag_n = 1'b1;
  logic [25:0] ctrl;
  logic [15:0] literal;
  logic        exec_valid;
  logic        halted;

  logic        ovr = 1'b0;
  logic [15:0] ovr_val = 16'h0000;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int cyc    = 0;
  int last_acc = 0;

  typedef struct { logic [15:0] addr; int gap; } fetch_t;
  typedef struct { logic [15:0] ir; logic [15:0] lit; } exec_t;
  fetch_t fq[$];
  exec_t  eq[$];
  fetch_t fe;
  exec_t  ee;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .instr(instr), .ir(ir),
    .dec_control(dec_control), .dec_literal(dec_literal),
    .flag_z(flag_z), .flag_n(flag_n),
    .ctrl(ctrl), .literal(literal),
    .exec_valid(exec_valid), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Program image
  function automatic logic [15:0] prog(input logic [15:0] a);
    case (a)
      16'h0003: prog = 16'h0ABC;
      16'h0004: prog = 16'hB00B;  // brz +11
      16'h0005: prog = 16'hFFFF;  // halt
      16'h0010: prog = 16'hB0FC;  // brz -4
      16'h0011: prog = 16'hB8ED;  // brn -19
      16'hFFFF: prog = 16'hB803;  // brn +3
      default:  prog = 16'h1234;
    endcase
  endfunction

  // External decoder stand-in
  assign instr       = ovr ? ovr_val : prog(mem_addr);
  assign dec_control = {ir[9:0], ir};
  assign dec_literal = (ir[15:12] == 4'hB) ? {{8{ir[7]}}, ir[7:0]} : 16'h0055;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_f(input logic [15:0] a, input int g);
    fetch_t f;
    f.addr = a; f.gap = g;
    fq.push_back(f);
  endtask

  task automatic push_e(input logic [15:0] i, input logic [15:0] l);
    exec_t e;
    e.ir = i; e.lit = l;
    eq.push_back(e);
  endtask

  // Returns at posedge+1 of the edge that accepted fetch k (state DECODE).
  task automatic wait_acc(input int k);
    int t;
    t = 0;
    while (n_acc < k && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("fetch_count_reached", n_acc, k);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req && mem_ready) begin
        n_acc++;
        if (fq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL fetch_unexpected: addr %h, none expected", mem_addr);
        end else begin
          fe = fq.pop_front();
          chk("fetch_addr", {16'h0, mem_addr}, {16'h0, fe.addr});
          if (fe.gap >= 0) chk("fetch_gap", cyc - last_acc, fe.gap);
        end
        last_acc = cyc;
      end
      if (exec_valid) begin
        if (eq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL exec_unexpected: ctrl %h, none expected", ctrl);
        end else begin
          ee = eq.pop_front();
          chk("exec_ctrl", {6'h0, ctrl}, {6'h0, ee.ir[9:0], ee.ir});
          chk("exec_literal", {16'h0, literal}, {16'h0, ee.lit});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_literal", literal, 0);
    chk("rst_exec_valid", exec_valid, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk); reset = 1'b0;

    // Zero-wait sequential fetches
    push_f(16'h0000, -1); push_f(16'h0001, 3); push_f(16'h0002, 3);
    push_e(16'h1234, 16'h0055); push_e(16'h1234, 16'h0055); push_e(16'h1234, 16'h0055);
    @(posedge clk); #1;
    chk("idle_no_req", mem_req, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_acc(3);

    // Wait-stated fetch at PC 3; instr toggles outside FETCH must not matter
    push_f(16'h0003, 7);
    push_e(16'h0ABC, 16'h0055);
    mem_ready = 1'b0;
    ovr = 1'b1; ovr_val = 16'hDEAD;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) begin
      chk("wait_mem_req", mem_req, 1);
      chk("wait_pc", mem_addr, 16'h0003);
      chk("wait_ir", ir, 16'h1234);
      @(posedge clk); #1;
    end
    ovr = 1'b0;
    mem_ready = 1'b1;

    // Branches: brz taken to 0010, brz -4 taken, loop, brz not taken,
    // brn to FFFF, brn wrap to 0003, brz not taken, halt
    push_f(16'h0004, 3); push_e(16'hB00B, 16'h000B);
    push_f(16'h0010, 3); push_e(16'hB0FC, 16'hFFFC);
    push_f(16'h000D, 3); push_e(16'h1234, 16'h0055);
    push_f(16'h000E, 3); push_e(16'h1234, 16'h0055);
    push_f(16'h000F, 3); push_e(16'h1234, 16'h0055);
    push_f(16'h0010, 3); push_e(16'hB0FC, 16'hFFFC);
    push_f(16'h0011, 3); push_e(16'hB8ED, 16'hFFED);
    push_f(16'hFFFF, 3); push_e(16'hB803, 16'h0003);
    push_f(16'h0003, 3); push_e(16'h0ABC, 16'h0055);
    push_f(16'h0004, 3); push_e(16'hB00B, 16'h000B);
    push_f(16'h0005, 3);
    wait_acc(8);
    flag_z = 1'b0;

    // Halt
    wait_acc(15);
    chk("decode_not_halted", halted, 0);
    @(posedge clk); #1;
    chk("halt_halted", halted, 1);
    chk("halt_mem_req", mem_req, 0);
    chk("halt_exec_valid", exec_valid, 0);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("halt_sticky", halted, 1);
      chk("halt_sticky_req", mem_req, 0);
    end
    start = 1'b0;

    // Reset out of HALT, then reset in the middle of EXECUTE
    reset = 1'b1; #1;
    chk("rst_from_halt", halted, 0);
    chk("rst_from_halt_pc", mem_addr, 16'h0000);
    @(negedge clk); reset = 1'b0;
    push_f(16'h0000, -1);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_acc(16);
    @(posedge clk); #1;
    chk("pre_rst_exec_valid", exec_valid, 1);
    chk("pre_rst_pc", mem_addr, 16'h0001);
    #1 reset = 1'b1;
    #1;
    chk("midexec_ctrl", ctrl, 0);
    chk("midexec_literal", literal, 0);
    chk("midexec_exec_valid", exec_valid, 0);
    chk("midexec_pc", mem_addr, 16'h0000);
    chk("midexec_mem_req", mem_req, 0);
    @(negedge clk); reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", mem_req, 0);
    chk("post_rst_pc", mem_addr, 16'h0000);

    chk("fetch_queue_drained", fq.size(), 0);
    chk("exec_queue_drained", eq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
